sdram_rom_loader: RTL and testbench

- Converts the byte-wide ioctl download stream from the MiST data_io block into 16-bit write requests.
- Writes are issued on one toggle req/ack port of the two-bank SDRAM controller (port1 or port2).
- Packs byte pairs into words, buffers them in a small FIFO, and keeps one write outstanding at a time.
- Signals when the last word of a download has been acknowledged by the controller.

---
 rtl/sdram_rom_loader.sv | 255 +++++++++++++++++++++++++
 tb/tb_sdram_rom_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rom_loader.sv
// Generic FIFO used by the loader; head is visible combinationally.
// Latency: one cycle from push to head/count update.
// Backpressure: pushes while full are ignored; pops while empty are ignored.
module sdram_rom_loader_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_vld_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_dat_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_push    = push_vld_i && (cnt_q != CW'(DEPTH));
    assign do_pop     = pop_i && (cnt_q != '0);
    assign head_dat_o = mem_q[rd_q];
    assign count_o    = cnt_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end
endmodule

// Packs the ioctl byte stream into 16-bit words and writes them over one SDRAM toggle port.
// Latency: a completed word is requested two edges after its final byte strobe.
// Backpressure: ioctl_wait_o at FIFO_DEPTH-1 entries; one write outstanding until port_ack_i.
module sdram_rom_loader #(
    parameter logic [22:0] BASE_ADDR  = 23'h000000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        init_n_i,
    input  logic        ioctl_downl_i,
    input  logic        ioctl_wr_i,
    input  logic [24:0] ioctl_addr_i,
    input  logic [7:0]  ioctl_dout_i,
    output logic        ioctl_wait_o,
    output logic        port_req_o,
    input  logic        port_ack_i,
    output logic        port_we_o,
    output logic [22:0] port_a_o,
    output logic [1:0]  port_ds_o,
    output logic [15:0] port_d_o,
    output logic        done_o,
    output logic        overflow_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [22:0] a;
        logic [15:0] d;
        logic [1:0]  ds;
    } word_t;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q;
    logic          port_req_q;
    logic [22:0]   port_a_q;
    logic [1:0]    port_ds_q;
    logic [15:0]   port_d_q;
    logic          downl_q;
    logic          active_q;
    logic          done_q;
    logic          overflow_q;

    logic          asm_vld_q, asm_vld_d;
    logic [23:0]   asm_waddr_q, asm_waddr_d;
    logic [15:0]   asm_data_q, asm_data_d;
    logic [1:0]    asm_mask_q, asm_mask_d;

    logic          strobe;
    logic          lane;
    logic [23:0]   waddr;
    logic [1:0]    lane_bit;
    logic [15:0]   merged_data;
    logic [1:0]    merged_mask;
    logic          downl_rise;
    logic          downl_fall;
    logic          push_vld;
    logic          push_drop;
    logic          pop;
    logic          done_cond;
    word_t         push_word;
    word_t         head;
    logic [CW-1:0] fifo_count;

    assign strobe      = ioctl_wr_i & ioctl_downl_i;
    assign waddr       = ioctl_addr_i[24:1];
    assign lane        = ioctl_addr_i[0];
    assign lane_bit    = lane ? 2'b10 : 2'b01;
    assign merged_data = lane ? {ioctl_dout_i, asm_data_q[7:0]} : {asm_data_q[15:8], ioctl_dout_i};
    assign merged_mask = asm_mask_q | lane_bit;
    assign downl_rise  = ioctl_downl_i & ~downl_q;
    assign downl_fall  = ~ioctl_downl_i & downl_q;

    // At most one push per cycle: a strobe either completes a word or evicts the held one.
    always_comb begin
        asm_vld_d    = asm_vld_q;
        asm_waddr_d  = asm_waddr_q;
        asm_data_d   = asm_data_q;
        asm_mask_d   = asm_mask_q;
        push_vld     = 1'b0;
        push_word.a  = asm_waddr_q[22:0] + BASE_ADDR;
        push_word.d  = asm_data_q;
        push_word.ds = asm_mask_q;
        if (strobe) begin
            if (asm_vld_q && (asm_waddr_q == waddr) && !asm_mask_q[lane]) begin
                if (merged_mask == 2'b11) begin
                    push_vld     = 1'b1;
                    push_word.d  = merged_data;
                    push_word.ds = 2'b11;
                    asm_vld_d    = 1'b0;
                    asm_data_d   = '0;
                    asm_mask_d   = '0;
                end else begin
                    asm_data_d = merged_data;
                    asm_mask_d = merged_mask;
                end
            end else begin
                push_vld    = asm_vld_q;
                asm_vld_d   = 1'b1;
                asm_waddr_d = waddr;
                asm_data_d  = lane ? {ioctl_dout_i, 8'h00} : {8'h00, ioctl_dout_i};
                asm_mask_d  = lane_bit;
            end
        end else if (downl_fall && asm_vld_q) begin
            push_vld   = 1'b1;
            asm_vld_d  = 1'b0;
            asm_data_d = '0;
            asm_mask_d = '0;
        end
    end

    assign push_drop = push_vld && (fifo_count == CW'(FIFO_DEPTH));
    assign pop       = (state_q == S_WAIT) && (port_ack_i == port_req_q);
    assign done_cond = active_q && !ioctl_downl_i && !asm_vld_q && (fifo_count == '0)
                       && (state_q == S_IDLE) && (port_req_q == port_ack_i);

    sdram_rom_loader_fifo #(
        .W     ($bits(word_t)),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_n_i    (init_n_i),
        .push_vld_i (push_vld),
        .push_dat_i (push_word),
        .pop_i      (pop),
        .head_dat_o (head),
        .count_o    (fifo_count)
    );

    always_ff @(posedge clk_i or negedge init_n_i) begin
        if (!init_n_i) begin
            asm_vld_q   <= 1'b0;
            asm_waddr_q <= '0;
            asm_data_q  <= '0;
            asm_mask_q  <= '0;
            downl_q     <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            asm_vld_q   <= asm_vld_d;
            asm_waddr_q <= asm_waddr_d;
            asm_data_q  <= asm_data_d;
            asm_mask_q  <= asm_mask_d;
            downl_q     <= ioctl_downl_i;
            done_q      <= done_cond;
            if (downl_rise) begin
                active_q <= 1'b1;
            end else if (done_cond) begin
                active_q <= 1'b0;
            end
            if (push_drop) begin
                overflow_q <= 1'b1;
            end else if (downl_rise) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Head stays in the FIFO until acknowledged, so a new download cannot disturb it.
    always_ff @(posedge clk_i or negedge init_n_i) begin
        if (!init_n_i) begin
            state_q    <= S_IDLE;
            port_req_q <= 1'b0;
            port_a_q   <= '0;
            port_ds_q  <= '0;
            port_d_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if ((fifo_count != '0) && (port_req_q == port_ack_i)) begin
                        port_a_q   <= head.a;
                        port_ds_q  <= head.ds;
                        port_d_q   <= head.d;
                        port_req_q <= ~port_req_q;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (port_ack_i == port_req_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ioctl_wait_o = fifo_count >= CW'(FIFO_DEPTH - 1);
    assign port_req_o   = port_req_q;
    assign port_we_o    = 1'b1;
    assign port_a_o     = port_a_q;
    assign port_ds_o    = port_ds_q;
    assign port_d_o     = port_d_q;
    assign done_o       = done_q;
    assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_sdram_rom_loader.sv
// Bench for sdram_rom_loader: directed and random downloads against a byte-level queue model.
// A built-in SDRAM controller model acknowledges each toggle request after a programmable delay.
`timescale 1ns/1ps
module tb_sdram_rom_loader;
    localparam int          DEPTH = 4;
    localparam logic [22:0] BASE  = 23'h000000;

    logic        clk = 1'b0;
    logic        init_n, downl, wr, ack;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        wait_o, req, we, done, ovf;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;

    always #5 clk = ~clk;

    sdram_rom_loader #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .init_n_i(init_n), .ioctl_downl_i(downl), .ioctl_wr_i(wr),
        .ioctl_addr_i(addr), .ioctl_dout_i(dout), .ioctl_wait_o(wait_o),
        .port_req_o(req), .port_ack_i(ack), .port_we_o(we), .port_a_o(a),
        .port_ds_o(ds), .port_d_o(d), .done_o(done), .overflow_o(ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: words sitting in the DUT FIFO, the partial word, and the flags.
    logic [40:0] m_q[$];
    logic        m_asm_vld = 1'b0;
    logic [23:0] m_wa = '0;
    logic [15:0] m_dat = '0;
    logic [1:0]  m_mask = '0;
    logic        m_active = 1'b0, m_ovf = 1'b0;
    logic        pend_push = 1'b0, pend_pop = 1'b0, pend_rise = 1'b0, s_cond = 1'b0;
    logic [40:0] pend_word = '0;
    logic        last_req = 1'b0;
    logic [40:0] issued = '0;
    int          ack_delay = 0, ack_cnt = 0, streak = 0, n_done = 0, mark = 0;
    logic        saw_wait = 1'b0;
    logic [41:0] log_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [40:0] mkword();
        return {m_wa[22:0] + BASE, m_dat, m_mask};
    endfunction

    // One clock cycle: apply the model effects of the edge just passed, compare, then drive.
    task automatic step(input logic dl, input logic w, input logic [24:0] ad, input logic [7:0] dt,
                        input bit honour, output bit took);
        logic        exp_done, drop, ack_new, ln;
        logic [40:0] cur;
        @(negedge clk);
        exp_done = s_cond;
        if (s_cond) m_active = 1'b0;
        if (pend_rise) begin m_active = 1'b1; m_ovf = 1'b0; end
        drop = pend_push && (m_q.size() == DEPTH);
        if (drop) m_ovf = 1'b1;
        if (pend_pop) void'(m_q.pop_front());
        if (pend_push && !drop) m_q.push_back(pend_word);

        chk("done", done, exp_done);
        if (done) n_done++;
        chk("overflow", ovf, m_ovf);
        chk("ioctl_wait", wait_o, m_q.size() >= DEPTH - 1);
        chk("port_we", we, 1);
        if (wait_o) saw_wait = 1'b1;
        cur = {a, d, ds};
        if (req !== last_req) begin
            chk("req_nonempty", m_q.size() != 0, 1);
            if (m_q.size() != 0) chk("req_word", cur, m_q[0]);
            log_q.push_back({req, cur});
            issued = cur; last_req = req; ack_cnt = 0; streak = 0;
        end else if (req !== ack) begin
            chk("req_held", cur, issued);
            streak = 0;
        end else if (m_q.size() != 0) begin
            streak++;
        end else begin
            streak = 0;
        end
        chk("issue_latency", streak <= 1, 1);

        ack_new = ack; pend_pop = 1'b0;
        if (req !== ack) begin
            if (ack_cnt >= ack_delay) begin ack_new = ~ack; pend_pop = 1'b1; end
            else ack_cnt++;
        end

        took = w && !(honour && wait_o);
        pend_rise = dl && !downl;
        s_cond = m_active && !dl && !m_asm_vld && (m_q.size() == 0) && (req === ack_new);
        pend_push = 1'b0;
        if (took && dl) begin
            ln = ad[0];
            if (m_asm_vld && ad[24:1] == m_wa && !m_mask[ln]) begin
                if (ln) m_dat[15:8] = dt; else m_dat[7:0] = dt;
                m_mask[ln] = 1'b1;
                if (m_mask == 2'b11) begin
                    pend_push = 1'b1; pend_word = mkword(); m_asm_vld = 1'b0;
                end
            end else begin
                if (m_asm_vld) begin pend_push = 1'b1; pend_word = mkword(); end
                m_asm_vld = 1'b1; m_wa = ad[24:1];
                m_dat = ln ? {dt, 8'h00} : {8'h00, dt};
                m_mask = ln ? 2'b10 : 2'b01;
            end
        end else if (downl && !dl && m_asm_vld) begin
            pend_push = 1'b1; pend_word = mkword(); m_asm_vld = 1'b0;
        end
        downl = dl; wr = took; addr = ad; dout = dt; ack = ack_new;
    endtask

    task automatic idle(input int n, input logic dl);
        bit t;
        for (int i = 0; i < n; i++) step(dl, 1'b0, '0, '0, 1'b1, t);
    endtask

    task automatic send(input logic [24:0] ad, input logic [7:0] dt, input bit honour);
        bit t;
        int tries = 0;
        do begin
            step(1'b1, 1'b1, ad, dt, honour, t);
            tries++;
        end while (!t && tries < 2000);
        chk("wait_timeout", t, 1);
    endtask

    task automatic dl_begin();
        n_done = 0;
        mark = log_q.size();
        idle(1, 1'b1);
    endtask

    task automatic dl_end();
        bit settled = 1'b0;
        idle(1, 1'b0);
        for (int i = 0; i < 3000 && !settled; i++) begin
            idle(1, 1'b0);
            settled = (m_q.size() == 0) && !m_asm_vld && !m_active && (req === ack) && !pend_push;
        end
        chk("drain_timeout", settled, 1);
        idle(2, 1'b0);
        chk("done_count", n_done, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        init_n = 1'b0; downl = 1'b0; wr = 1'b0; ack = 1'b0;
        #1;
        chk("rst_req", req, 0);
        chk("rst_a", a, 0);
        chk("rst_ds", ds, 0);
        chk("rst_d", d, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_wait", wait_o, 0);
        chk("rst_we", we, 1);
        m_q.delete();
        m_asm_vld = 1'b0; m_mask = '0; m_active = 1'b0; m_ovf = 1'b0;
        pend_push = 1'b0; pend_pop = 1'b0; pend_rise = 1'b0; s_cond = 1'b0;
        last_req = 1'b0; streak = 0; ack_cnt = 0;
        @(negedge clk);
        init_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [24:0] ra;
        int          len;
        bit          hon;
        init_n = 1'b0; downl = 1'b0; wr = 1'b0; addr = '0; dout = '0; ack = 1'b0;
        do_reset();

        // Four bytes, two full words.
        ack_delay = 0;
        dl_begin();
        send(25'h0, 8'h11, 1); send(25'h1, 8'h22, 1); send(25'h2, 8'h33, 1); send(25'h3, 8'h44, 1);
        dl_end();
        chk("t1_nreq", log_q.size() - mark, 2);
        chk("t1_w0", log_q[mark][40:0], {23'd0, 16'h2211, 2'b11});
        chk("t1_w1", log_q[mark+1][40:0], {23'd1, 16'h4433, 2'b11});

        // Odd length: last byte flushed by the downl fall.
        dl_begin();
        send(25'h10, 8'hAA, 1); send(25'h11, 8'hBB, 1); send(25'h12, 8'hCC, 1);
        dl_end();
        chk("t2_nreq", log_q.size() - mark, 2);
        chk("t2_w0", log_q[mark][40:0], {23'd8, 16'hBBAA, 2'b11});
        chk("t2_w1", log_q[mark+1][40:0], {23'd9, 16'h00CC, 2'b01});

        // Non-contiguous bytes.
        dl_begin();
        send(25'h5, 8'h55, 1); send(25'h8, 8'h88, 1);
        dl_end();
        chk("t3_nreq", log_q.size() - mark, 2);
        chk("t3_w0", log_q[mark][40:0], {23'd2, 16'h5500, 2'b10});
        chk("t3_w1", log_q[mark+1][40:0], {23'd4, 16'h0088, 2'b01});

        // Slow controller, streaming upstream that honours ioctl_wait.
        ack_delay = 20; saw_wait = 1'b0;
        dl_begin();
        for (int i = 0; i < 32; i++) send(25'h100 + 25'(i), 8'(i * 7), 1);
        dl_end();
        chk("t4_nreq", log_q.size() - mark, 16);
        for (int i = 0; i < 16; i++) chk("t4_seq", log_q[mark+i][40:18], 23'h80 + 23'(i));
        chk("t4_ovf", ovf, 0);
        chk("t4_wait_seen", saw_wait, 1);

        // Forced strobes into a full FIFO.
        ack_delay = 30;
        dl_begin();
        for (int i = 0; i < 8; i++) send(25'h200 + 25'(2 * i), 8'(i), 0);
        dl_end();
        chk("t5_nreq", log_q.size() - mark, 4);
        for (int i = 0; i < 4; i++) chk("t5_addr", log_q[mark+i][40:18], 23'h100 + 23'(i));
        chk("t5_ovf_set", ovf, 1);

        // Zero-byte download; its rise also clears overflow.
        ack_delay = 0;
        dl_begin();
        idle(1, 1'b1);
        chk("t6_ovf_clear", ovf, 0);
        dl_end();
        chk("t6_nreq", log_q.size() - mark, 0);

        // Reset with a request outstanding.
        ack_delay = 1000;
        dl_begin();
        send(25'h0, 8'h01, 1); send(25'h1, 8'h02, 1);
        idle(3, 1'b1);
        chk("t7_pending", req !== ack, 1);
        do_reset();
        ack_delay = 0;
        dl_begin();
        send(25'h20, 8'hA5, 1); send(25'h21, 8'h5A, 1);
        dl_end();
        chk("t7_first_req", log_q[mark], {1'b1, 23'h10, 16'h5AA5, 2'b11});

        // Random downloads.
        for (int k = 0; k < 8; k++) begin
            ack_delay = $urandom_range(0, 6);
            hon = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 3) == 0) ? 25'h1FFFFF8 : 25'($urandom);
            len = $urandom_range(0, 12);
            dl_begin();
            for (int i = 0; i < len; i++) begin
                send(ra, 8'($urandom), hon);
                idle($urandom_range(0, 2), 1'b1);
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: ra = ra + 25'd1;
                    6, 7:             ra = ra;
                    default:          ra = ra + 25'($urandom_range(2, 9));
                endcase
            end
            dl_end();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
